// File: rtl/qspi_prog_pkg.sv
// Shared opcodes, error codes, FSM states and size constants for the
// QSPI flash-update sequencer.
package qspi_prog_pkg;

  localparam int unsigned ADDR_W            = 24;
  localparam int unsigned PAGE_BYTES_DFLT   = 256;
  localparam int unsigned SECTOR_BYTES_DFLT = 4096;

  localparam logic [2:0] OP_PP = 3'd1;
  localparam logic [2:0] OP_SE = 3'd2;

  typedef enum logic [2:0] {
    ERR_OK      = 3'd0,
    ERR_ALIGN   = 3'd1,
    ERR_RANGE   = 3'd2,
    ERR_ENGINE  = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_ABORT   = 3'd5
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SE_ISSUE,
    ST_SE_WAIT,
    ST_PP_ISSUE,
    ST_PP_DATA,
    ST_PP_WAIT,
    ST_FINISH
  } state_e;

  // Page-program chunk: what is left, capped at the room left in the current page.
  function automatic logic [8:0] pp_chunk(input logic [23:0] remaining,
                                          input logic [8:0]  room);
    if (remaining < {15'd0, room}) return remaining[8:0];
    else                           return room;
  endfunction

endpackage

// File: rtl/qspi_op_watchdog.sv
// Per-operation watchdog: loaded when an engine op starts, cleared when it ends,
// flags expiry once TIMEOUT_CYCLES have elapsed without a clear.
module qspi_op_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             active;

  always_ff @(posedge HCLK) begin
    if (HRESET || clear) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= CNT_W'(TIMEOUT_CYCLES);
      active <= 1'b1;
    end else if (active && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = active && (cnt == '0);

endmodule

// File: rtl/qspi_update_seq.sv
// Flash-update sequencer: erases the covering sectors of a region, then streams
// the region into page-program ops split at page boundaries.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | waiting for cmd_start
//   ST_CHECK    | validate length, range and sector alignment
//   ST_SE_ISSUE | wait for engine idle, launch sector erase
//   ST_SE_WAIT  | erase in flight
//   ST_PP_ISSUE | wait for engine idle, launch page program
//   ST_PP_DATA  | forward source bytes to the engine
//   ST_PP_WAIT  | all bytes handed over, waiting for completion
//   ST_FINISH   | one-cycle done pulse, err_code valid
module qspi_update_seq
  import qspi_prog_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned PAGE_BYTES     = PAGE_BYTES_DFLT,
  parameter int unsigned SECTOR_BYTES   = SECTOR_BYTES_DFLT
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_start,
  input  logic        cmd_erase,
  input  logic [23:0] cmd_addr,
  input  logic [23:0] cmd_len,
  input  logic        cmd_abort,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        prog_start,
  output logic [2:0]  prog_op,
  output logic [23:0] prog_addr,
  output logic [8:0]  prog_byte_count,
  output logic [7:0]  prog_data_in,
  output logic        prog_data_valid,
  input  logic        prog_data_req,
  input  logic        prog_busy,
  input  logic        prog_done,
  input  logic        prog_error,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_code,
  output logic [23:0] cur_addr
);

  state_e      state, state_d;
  err_e        err_q, err_d;
  logic [23:0] cur_q, rem_q, rem_after;
  logic [24:0] end_q, sec_q, sec_next;
  logic        erase_q, abort_q, abort_hit;
  logic [8:0]  chunk_q, chunk_cnt, chunk_next, page_off, page_room;
  logic        start_acc, issue_se, issue_pp, se_done, pp_commit, byte_acc;
  logic        wd_expired, wd_clear;

  assign page_off   = 9'(cur_q & 24'(PAGE_BYTES - 1));
  assign page_room  = 9'(PAGE_BYTES) - page_off;
  assign chunk_next = pp_chunk(rem_q, page_room);
  assign rem_after  = rem_q - 24'(chunk_q);
  assign sec_next   = sec_q + 25'(SECTOR_BYTES);
  assign abort_hit  = abort_q || cmd_abort;
  assign byte_acc   = (state == ST_PP_DATA) && src_valid && prog_data_req;

  always_comb begin
    state_d   = state;
    err_d     = err_q;
    start_acc = 1'b0;
    issue_se  = 1'b0;
    issue_pp  = 1'b0;
    se_done   = 1'b0;
    pp_commit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_start) begin
          start_acc = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rem_q == 24'd0) begin
          state_d = ST_FINISH;
          err_d   = ERR_OK;
        end else if (end_q > 25'h100_0000) begin
          state_d = ST_FINISH;
          err_d   = ERR_RANGE;
        end else if (erase_q && (cur_q & 24'(SECTOR_BYTES - 1)) != 24'd0) begin
          state_d = ST_FINISH;
          err_d   = ERR_ALIGN;
        end else begin
          state_d = erase_q ? ST_SE_ISSUE : ST_PP_ISSUE;
        end
      end
      ST_SE_ISSUE: begin
        if (abort_hit) begin
          state_d = ST_FINISH;
          err_d   = ERR_ABORT;
        end else if (!prog_busy) begin
          issue_se = 1'b1;
          state_d  = ST_SE_WAIT;
        end
      end
      ST_SE_WAIT: begin
        if (prog_error) begin
          state_d = ST_FINISH;
          err_d   = ERR_ENGINE;
        end else if (prog_done) begin
          se_done = 1'b1;
          state_d = (sec_next < end_q) ? ST_SE_ISSUE : ST_PP_ISSUE;
        end else if (wd_expired) begin
          state_d = ST_FINISH;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_PP_ISSUE: begin
        if (abort_hit) begin
          state_d = ST_FINISH;
          err_d   = ERR_ABORT;
        end else if (!prog_busy) begin
          issue_pp = 1'b1;
          state_d  = ST_PP_DATA;
        end
      end
      ST_PP_DATA, ST_PP_WAIT: begin
        // The engine may complete or fail before it has pulled every byte.
        if (prog_error) begin
          state_d = ST_FINISH;
          err_d   = ERR_ENGINE;
        end else if (prog_done) begin
          pp_commit = 1'b1;
          state_d   = (rem_after != 24'd0) ? ST_PP_ISSUE : ST_FINISH;
        end else if (state == ST_PP_DATA && byte_acc && chunk_cnt == 9'd1) begin
          state_d = ST_PP_WAIT;
        end else if (wd_expired) begin
          state_d = ST_FINISH;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cur_q           <= '0;
      rem_q           <= '0;
      end_q           <= '0;
      sec_q           <= '0;
      erase_q         <= 1'b0;
      abort_q         <= 1'b0;
      err_q           <= ERR_OK;
      chunk_q         <= '0;
      chunk_cnt       <= '0;
      prog_start      <= 1'b0;
      prog_op         <= '0;
      prog_addr       <= '0;
      prog_byte_count <= '0;
    end else begin
      prog_start <= issue_se || issue_pp;
      if (start_acc) begin
        cur_q   <= cmd_addr;
        rem_q   <= cmd_len;
        sec_q   <= {1'b0, cmd_addr};
        end_q   <= {1'b0, cmd_addr} + {1'b0, cmd_len};
        erase_q <= cmd_erase;
        err_q   <= ERR_OK;
        abort_q <= 1'b0;
      end else begin
        err_q   <= err_d;
        abort_q <= (state == ST_IDLE || state == ST_FINISH) ? 1'b0 : abort_hit;
      end
      if (issue_se) begin
        prog_op         <= OP_SE;
        prog_addr       <= sec_q[23:0];
        prog_byte_count <= 9'd0;
      end
      if (issue_pp) begin
        prog_op         <= OP_PP;
        prog_addr       <= cur_q;
        prog_byte_count <= chunk_next;
        chunk_q         <= chunk_next;
        chunk_cnt       <= chunk_next;
      end else if (byte_acc && chunk_cnt != 9'd0) begin
        chunk_cnt <= chunk_cnt - 9'd1;
      end
      if (se_done) sec_q <= sec_next;
      if (pp_commit) begin
        cur_q <= cur_q + 24'(chunk_q);
        rem_q <= rem_after;
      end
    end
  end

  assign wd_clear = se_done || pp_commit || (state_d == ST_FINISH);

  qspi_op_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .load    (issue_se || issue_pp),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  assign busy            = (state != ST_IDLE) && (state != ST_FINISH);
  assign done            = (state == ST_FINISH);
  assign src_ready       = (state == ST_PP_DATA) && prog_data_req;
  assign prog_data_valid = byte_acc;
  assign prog_data_in    = src_data;
  assign err_code        = err_q;
  assign cur_addr        = cur_q;

endmodule

// File: tb/tb_qspi_update_seq.sv
// Directed bench for qspi_update_seq: an engine/source model checks every
// issued op and byte against scoreboard queues filled before each command.
module tb_qspi_update_seq;
  import qspi_prog_pkg::*;

  localparam int unsigned TMO = 600;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_start = 1'b0, cmd_erase = 1'b0, cmd_abort = 1'b0;
  logic [23:0] cmd_addr = '0, cmd_len = '0;
  logic [7:0]  src_data;
  logic        src_valid, src_ready;
  logic        prog_start, prog_data_valid, prog_data_req, prog_busy, prog_done, prog_error;
  logic [2:0]  prog_op;
  logic [23:0] prog_addr;
  logic [8:0]  prog_byte_count;
  logic [7:0]  prog_data_in;
  logic        busy, done;
  logic [2:0]  err_code;
  logic [23:0] cur_addr;

  qspi_update_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_start(cmd_start), .cmd_erase(cmd_erase), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_abort(cmd_abort),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .prog_start(prog_start), .prog_op(prog_op), .prog_addr(prog_addr),
    .prog_byte_count(prog_byte_count), .prog_data_in(prog_data_in),
    .prog_data_valid(prog_data_valid), .prog_data_req(prog_data_req),
    .prog_busy(prog_busy), .prog_done(prog_done), .prog_error(prog_error),
    .busy(busy), .done(done), .err_code(err_code), .cur_addr(cur_addr)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [2:0]  op;
    logic [23:0] addr;
    logic [8:0]  cnt;
  } op_t;

  op_t        exp_ops[$];
  logic [7:0] exp_bytes[$];
  int total = 0, bad = 0;
  int cyc = 0, start_cyc = 0;
  int src_idx = 0, push_idx = 0, op_idx = 0, err_at = -1;
  bit hang = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) ^ (i >> 8));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine and source model; drives at the falling edge, samples 1 unit later.
  typedef enum {E_IDLE, E_DATA, E_DELAY} eng_e;
  eng_e eng = E_IDLE;
  int   n = 0, cnt = 0, dly = 0, cur_op = 0;
  initial begin
    op_t e;
    prog_data_req = 1'b0; prog_busy = 1'b0; prog_done = 1'b0; prog_error = 1'b0;
    src_valid = 1'b0; src_data = '0;
    forever begin
      @(negedge HCLK);
      prog_done  = 1'b0;
      prog_error = 1'b0;
      src_valid  = ($urandom_range(0, 3) != 0);
      src_data   = pat(src_idx);
      case (eng)
        E_DATA: prog_data_req = 1'b1;
        E_DELAY: begin
          prog_data_req = 1'b0;
          if (dly == 0) begin
            if (cur_op == err_at) prog_error = 1'b1;
            else if (!hang)       prog_done  = 1'b1;
            prog_busy = 1'b0;
            eng = E_IDLE;
          end else dly--;
        end
        default: prog_data_req = 1'b0;
      endcase
      #1;
      if (HRESET) begin
        eng = E_IDLE; prog_busy = 1'b0; prog_data_req = 1'b0;
        prog_done = 1'b0; prog_error = 1'b0;
      end else begin
        if (prog_start) begin
          if (exp_ops.size() == 0) chk("unexpected_start", 32'(exp_ops.size()), 32'd1);
          else begin
            e = exp_ops.pop_front();
            chk("op", 32'(prog_op), 32'(e.op));
            chk("op_addr", 32'(prog_addr), 32'(e.addr));
            chk("op_count", 32'(prog_byte_count), 32'(e.cnt));
          end
          cur_op = op_idx; op_idx++;
          start_cyc = cyc;
          prog_busy = 1'b1;
          if (prog_op == OP_PP) begin eng = E_DATA; n = 0; cnt = int'(prog_byte_count); end
          else begin eng = E_DELAY; dly = 3; end
        end
        if (prog_data_valid) begin
          if (exp_bytes.size() == 0) chk("extra_byte", 32'(exp_bytes.size()), 32'd1);
          else chk("byte", 32'(prog_data_in), 32'(exp_bytes.pop_front()));
          src_idx++; n++;
          if (eng == E_DATA && n >= cnt) begin eng = E_DELAY; dly = 2; end
        end
      end
    end
  end

  task automatic reset_sb();
    exp_ops.delete(); exp_bytes.delete();
    push_idx = 0; src_idx = 0; op_idx = 0;
  endtask

  task automatic push_se(input logic [23:0] a);
    exp_ops.push_back('{OP_SE, a, 9'd0});
  endtask

  task automatic push_pp(input logic [23:0] a, input int c);
    exp_ops.push_back('{OP_PP, a, 9'(c)});
    for (int i = 0; i < c; i++) begin exp_bytes.push_back(pat(push_idx)); push_idx++; end
  endtask

  task automatic start_cmd(input logic [23:0] a, input logic [23:0] l, input logic e);
    @(negedge HCLK);
    cmd_addr = a; cmd_len = l; cmd_erase = e; cmd_start = 1'b1;
    @(negedge HCLK);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin @(negedge HCLK); k++; end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic end_checks(input string tag, input err_e exp_err,
                            input bit chk_cur, input logic [23:0] exp_cur);
    chk({tag, "_err"}, 32'(err_code), 32'(exp_err));
    if (chk_cur) chk({tag, "_cur_addr"}, 32'(cur_addr), 32'(exp_cur));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_ops_left"}, 32'(exp_ops.size()), 32'd0);
    chk({tag, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
    @(negedge HCLK);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_prog_start", 32'(prog_start), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_cur_addr", 32'(cur_addr), 32'd0);

    // Page-crossing program; a second cmd_start while busy must be ignored.
    reset_sb();
    push_pp(24'h0000F0, 16); push_pp(24'h000100, 16);
    start_cmd(24'h0000F0, 24'h20, 1'b0);
    repeat (5) @(negedge HCLK);
    chk("busy_mid", 32'(busy), 32'd1);
    cmd_addr = 24'h005000; cmd_start = 1'b1;
    @(negedge HCLK);
    cmd_start = 1'b0;
    wait_done(2000);
    end_checks("pp_cross", ERR_OK, 1'b1, 24'h000110);

    // Two-sector erase followed by 16 full pages and one trailing byte.
    reset_sb();
    push_se(24'h001000); push_se(24'h002000);
    for (int p = 0; p < 16; p++) push_pp(24'h001000 + 24'(p * 256), 256);
    push_pp(24'h002000, 1);
    start_cmd(24'h001000, 24'h001001, 1'b1);
    wait_done(20000);
    end_checks("erase_prog", ERR_OK, 1'b1, 24'h002001);

    reset_sb();
    start_cmd(24'h001080, 24'h10, 1'b1);
    wait_done(20);
    end_checks("align", ERR_ALIGN, 1'b1, 24'h001080);

    reset_sb();
    start_cmd(24'hFFFF00, 24'h101, 1'b0);
    wait_done(20);
    end_checks("range", ERR_RANGE, 1'b0, 24'h0);

    // Last page of the address space is legal.
    reset_sb();
    push_pp(24'hFFFF00, 256);
    start_cmd(24'hFFFF00, 24'h100, 1'b0);
    wait_done(2000);
    end_checks("top_page", ERR_OK, 1'b0, 24'h0);

    // Zero length wins over a misaligned erase request.
    reset_sb();
    start_cmd(24'h123456, 24'h0, 1'b1);
    wait_done(20);
    end_checks("len_zero", ERR_OK, 1'b0, 24'h0);

    // Engine error on the second page program.
    reset_sb();
    err_at = 1;
    push_pp(24'h0000F0, 16); push_pp(24'h000100, 256);
    start_cmd(24'h0000F0, 24'h120, 1'b0);
    wait_done(3000);
    end_checks("engine_err", ERR_ENGINE, 1'b1, 24'h000100);
    repeat (10) @(negedge HCLK);
    err_at = -1;

    // Erase never completes: FINISH is entered on the cycle after the
    // watchdog reaches zero, TMO cycles after the prog_start edge.
    reset_sb();
    hang = 1'b1;
    push_se(24'h003000);
    start_cmd(24'h003000, 24'h1, 1'b1);
    wait_done(TMO + 50);
    chk("timeout_latency", 32'(cyc - start_cyc), 32'(TMO + 1));
    end_checks("timeout", ERR_TIMEOUT, 1'b0, 24'h0);
    hang = 1'b0;

    // One-cycle abort pulse during the first page: that page still completes.
    reset_sb();
    push_pp(24'h000000, 256);
    start_cmd(24'h000000, 24'h300, 1'b0);
    repeat (10) @(negedge HCLK);
    cmd_abort = 1'b1;
    @(negedge HCLK);
    cmd_abort = 1'b0;
    wait_done(3000);
    end_checks("abort", ERR_ABORT, 1'b1, 24'h000100);

    // Reset in the middle of a page transfer, then a fresh command.
    reset_sb();
    push_pp(24'h000000, 256);
    start_cmd(24'h000000, 24'h100, 1'b0);
    repeat (20) @(negedge HCLK);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_src_ready", 32'(src_ready), 32'd0);
    chk("mid_rst_err", 32'(err_code), 32'd0);
    chk("mid_rst_cur_addr", 32'(cur_addr), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    reset_sb();
    push_pp(24'h000040, 8);
    start_cmd(24'h000040, 24'h8, 1'b0);
    wait_done(500);
    end_checks("post_rst", ERR_OK, 1'b1, 24'h000048);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
